// File: rtl/bit_counter_param.sv
// bit_counter_param: counts the 1-bits (or 0-bits) of an operand by shifting
// it right one position per cycle, started by an asynchronous level request.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset_n      in   synchronous active-low reset
//   start        in   raw asynchronous request, level sensitive
//   count_zeros  in   0: count 1-bits of A, 1: count 0-bits of A
//   A            in   WIDTH-bit operand, sampled while idle
//   result       out  RW-bit count, driven straight from a register
//   busy         out  high while counting
//   done         out  high while the result is presented
module bit_counter_param #(
    parameter  int WIDTH       = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int RW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             count_zeros,
    input  logic [WIDTH-1:0] A,
    output logic [RW-1:0]    result,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [RW-1:0]    result_q;
    logic [RW-1:0]    result_d;

    // Shift chain: the request enters at bit 0 and leaves at the top bit.
    generate
        if (SYNC_STAGES == 1) begin : g_sync1
            assign sync_d = start;
        end else begin : g_syncn
            assign sync_d = {sync_q[SYNC_STAGES-2:0], start};
        end
    endgenerate

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                // Operand and mode are captured every idle cycle, so the
                // value frozen for counting is the one of the last idle cycle.
                a_d      = count_zeros ? ~A : A;
                result_d = '0;
                if (s) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // Stops as soon as no set bits remain, so the run length
                // follows the highest set bit, not WIDTH.
                if (a_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    a_d      = a_q >> 1;
                    result_d = result_q + RW'(a_q[0]);
                end
            end
            S_DONE: begin
                // A held request keeps us here; it must drop to re-arm.
                if (!s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                a_d      = '0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= '0;
            state_q  <= S_IDLE;
            a_q      <= '0;
            result_q <= '0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            a_q      <= a_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == S_COUNT);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_bit_counter_param.sv
// Self-checking bench for bit_counter_param (WIDTH=8, SYNC_STAGES=2).
// Randomized and directed runs against a popcount/msb reference model.
module tb_bit_counter_param;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int RW = $clog2(W + 1);

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          count_zeros;
    logic [W-1:0]  A;
    logic [RW-1:0] result;
    logic          busy;
    logic          done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bit_counter_param #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .count_zeros(count_zeros),
        .A          (A),
        .result     (result),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int ref_count(input logic [W-1:0] a, input logic cz);
        int n = 0;
        for (int i = 0; i < W; i++) begin
            if (a[i] != cz) n++;
        end
        return n;
    endfunction

    function automatic int ref_dur(input logic [W-1:0] a, input logic cz);
        logic [W-1:0] v;
        int hi = -1;
        v = cz ? ~a : a;
        for (int i = 0; i < W; i++) begin
            if (v[i]) hi = i;
        end
        return (hi < 0) ? 1 : hi + 2;
    endfunction

    // Raise start with the given operand and measure the run. Start stays high.
    task automatic do_run(input logic [W-1:0] a, input logic cz,
                          input bit chg, input logic [W-1:0] a2,
                          output int lat, output int dur,
                          output logic [RW-1:0] res, output logic dn,
                          output bit to);
        to = 0;
        A = a;
        count_zeros = cz;
        start = 1'b1;
        lat = 0;
        while (!busy && lat < 20) begin
            tick();
            lat++;
        end
        if (!busy) to = 1;
        if (chg) begin
            A = a2;
            count_zeros = ~cz;
        end
        dur = 0;
        while (busy && dur < 40) begin
            tick();
            dur++;
        end
        if (busy) to = 1;
        res = result;
        dn = done;
    endtask

    // Drop start and wait for the return to idle.
    task automatic release_start(output int lat);
        start = 1'b0;
        lat = 0;
        while (done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        count_zeros = 1'b0;
        A = '0;
        tick();
        tick();
        total_cnt++;
        if ({busy, done, result} !== '0)
            $display("FAIL reset_state: busy=%b done=%b result=%0d want 0 0 0",
                     busy, done, result);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({busy, done, result} !== '0)
            $display("FAIL idle_after_reset: busy=%b done=%b result=%0d want 0 0 0",
                     busy, done, result);
        else pass_cnt++;
    endtask

    task automatic test_case(input string nm, input logic [W-1:0] a,
                             input logic cz, input bit chg,
                             input logic [W-1:0] a2);
        int lat, dur, rl;
        logic [RW-1:0] res;
        logic dn;
        bit to;
        do_run(a, cz, chg, a2, lat, dur, res, dn, to);
        total_cnt++;
        if (to || lat != SS + 1)
            $display("FAIL %s latency: got %0d (timeout=%0b) want %0d",
                     nm, lat, to, SS + 1);
        else pass_cnt++;
        total_cnt++;
        if (dur != ref_dur(a, cz))
            $display("FAIL %s busy_cycles: got %0d want %0d",
                     nm, dur, ref_dur(a, cz));
        else pass_cnt++;
        total_cnt++;
        if (dn !== 1'b1 || res !== RW'(ref_count(a, cz)))
            $display("FAIL %s result: done=%b result=%0d want 1 %0d",
                     nm, dn, res, ref_count(a, cz));
        else pass_cnt++;
        release_start(rl);
        total_cnt++;
        if (rl != SS + 1 || busy !== 1'b0)
            $display("FAIL %s release: got %0d busy=%b want %0d 0",
                     nm, rl, busy, SS + 1);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_hold_done();
        int lat, dur, rl;
        logic [RW-1:0] res;
        logic dn;
        bit to;
        do_run(8'hA5, 1'b0, 1'b0, '0, lat, dur, res, dn, to);
        A = 8'h00;
        for (int i = 0; i < 6; i++) tick();
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== RW'(4))
            $display("FAIL hold_done: done=%b busy=%b result=%0d want 1 0 4",
                     done, busy, result);
        else pass_cnt++;
        release_start(rl);
        tick();
        total_cnt++;
        if (result !== '0 || done !== 1'b0)
            $display("FAIL idle_clear: result=%0d done=%b want 0 0",
                     result, done);
        else pass_cnt++;
        do_run(8'h07, 1'b0, 1'b0, '0, lat, dur, res, dn, to);
        total_cnt++;
        if (to || dur != 4 || res !== RW'(3) || dn !== 1'b1)
            $display("FAIL retrigger: dur=%0d result=%0d done=%b want 4 3 1",
                     dur, res, dn);
        else pass_cnt++;
        release_start(rl);
        tick();
    endtask

    task automatic test_reset_mid_count();
        int lat, dur, rl;
        bit to;
        A = 8'hA5;
        count_zeros = 1'b0;
        start = 1'b1;
        lat = 0;
        while (!busy && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        total_cnt++;
        if ({busy, done, result} !== '0)
            $display("FAIL mid_reset: busy=%b done=%b result=%0d want 0 0 0",
                     busy, done, result);
        else pass_cnt++;
        reset_n = 1'b1;
        A = 8'h3C;
        lat = 0;
        while (!busy && lat < 20) begin
            tick();
            lat++;
        end
        total_cnt++;
        if (lat != SS + 1)
            $display("FAIL restart_latency: got %0d want %0d", lat, SS + 1);
        else pass_cnt++;
        dur = 0;
        to = 0;
        while (busy && dur < 40) begin
            tick();
            dur++;
        end
        total_cnt++;
        if (dur != 7 || result !== RW'(4) || done !== 1'b1)
            $display("FAIL after_reset_run: dur=%0d result=%0d done=%b want 7 4 1",
                     dur, result, done);
        else pass_cnt++;
        release_start(rl);
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic cz;
        int lat, dur, rl;
        logic [RW-1:0] res;
        logic dn;
        bit to;
        for (int n = 0; n < 24; n++) begin
            a = W'($urandom);
            cz = 1'($urandom_range(0, 1));
            do_run(a, cz, 1'b1, W'($urandom), lat, dur, res, dn, to);
            total_cnt++;
            if (to || lat != SS + 1 || dur != ref_dur(a, cz) ||
                dn !== 1'b1 || res !== RW'(ref_count(a, cz)))
                $display("FAIL random A=%h cz=%b: lat=%0d dur=%0d res=%0d want %0d %0d %0d",
                         a, cz, lat, dur, res, SS + 1, ref_dur(a, cz),
                         ref_count(a, cz));
            else pass_cnt++;
            release_start(rl);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_case("a5", 8'hA5, 1'b0, 1'b0, '0);
        test_case("f0_zeros", 8'hF0, 1'b1, 1'b0, '0);
        test_case("zero", 8'h00, 1'b0, 1'b0, '0);
        test_case("ff_zeros", 8'hFF, 1'b1, 1'b0, '0);
        test_case("ff_ones", 8'hFF, 1'b0, 1'b0, '0);
        test_case("a5_change", 8'hA5, 1'b0, 1'b1, 8'h01);
        test_hold_done();
        test_reset_mid_count();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bit_counter_param.md
BIT_COUNTER_PARAM -- requirements
Module: bit_counter_param

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..64.
REQ-002 Parameter SYNC_STAGES, default 2: number of flip-flop stages on start, legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  raw, asynchronous request, active high (level, not pulse).
REQ-006 count_zeros  input  1  mode: 0 counts 1-bits of A; 1 counts 0-bits of A.
REQ-007 A  input  WIDTH  operand.
REQ-008 result  output  RW = $clog2(WIDTH+1)  number of counted bits.
REQ-009 busy  output  1  high while in S_COUNT.
REQ-010 done  output  1  high while in S_DONE.

Function
REQ-011 start SHALL pass through SYNC_STAGES flip-flops; s denotes the last stage, and only s drives the FSM.
REQ-012 FSM states SHALL be S_IDLE, S_COUNT and S_DONE; the encoding is free.
REQ-013 S_IDLE, every cycle: a_reg <= count_zeros ? ~A : A; result <= 0.
REQ-014 S_IDLE with s=1: next state S_COUNT; the load from REQ-013 still occurs that cycle.
REQ-015 S_IDLE with s=0: remain in S_IDLE.
REQ-016 S_COUNT, a_reg==0: next state S_DONE; no shift, result unchanged.
REQ-017 S_COUNT, a_reg!=0: a_reg <= a_reg>>1 (zero fill); result <= result + a_reg[0]; remain in S_COUNT.
REQ-018 In S_COUNT, A and count_zeros SHALL be ignored; the operand and mode are frozen at the last S_IDLE cycle.
REQ-019 S_COUNT SHALL last msb(a_reg)+2 cycles for nonzero a_reg, where msb is the index of the highest set bit, and 1 cycle for a_reg==0.
REQ-020 S_DONE: result held; next state S_IDLE when s=0, else remain in S_DONE.
REQ-021 A held start SHALL NOT retrigger; a new count requires s to drop, then rise again.
REQ-022 result SHALL never overflow: its maximum is WIDTH, which is representable in RW bits.
REQ-023 Latency from start rising (setup met) to s=1 SHALL be SYNC_STAGES cycles.
REQ-024 Total latency from s=1 in S_IDLE to done=1 SHALL be 1 + the S_COUNT duration from REQ-019.
REQ-025 busy and done SHALL be Moore outputs decoded from state only, and never both high.
REQ-026 result SHALL be driven directly from its register, with no combinational path from A.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force, on the next cycle: state S_IDLE; result=0; busy=0; done=0; a_reg=0; all synchronizer stages=0.
REQ-028 Reset SHALL take priority over every transition, including a reset asserted mid S_COUNT or in S_DONE.
REQ-029 Outputs SHALL be defined from the first edge with reset_n=0, with no dependence on an initial block.
REQ-030 After reset_n returns to 1, start already high SHALL begin a count after SYNC_STAGES cycles.

Verification (WIDTH=8, SYNC_STAGES=2)
REQ-031 A=8'hA5, count_zeros=0, pulse start high -> busy for 9 cycles, then done=1 with result=4; result holds while start stays high.
REQ-032 A=8'hF0, count_zeros=1 -> a_reg=8'h0F, busy for 5 cycles, result=4, done=1.
REQ-033 Boundary cases:
- A=8'h00 with count_zeros=0 -> busy for 1 cycle, result=0.
- A=8'hFF with count_zeros=1 -> result=0.
- A=8'hFF with count_zeros=0 -> busy for 9 cycles, result=8 (maximum, no wrap).
REQ-034 A changed to 8'h01 mid S_COUNT of the 8'hA5 run -> result still 4.
REQ-035 Hold start high after done -> stays in S_DONE; drop start -> S_IDLE with result=0 one cycle later; raise start again -> new count.
REQ-036 reset_n=0 for 1 cycle during S_COUNT -> next cycle busy=0, done=0, result=0; a subsequent run completes correctly.
